alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
- Sits directly downstream of the push-button debouncers. It consumes their single-cycle "pressed" pulses plus the raw data switches.
- Steps the user through entering operand A, operand B and the opcode, then issues a one-cycle start to the ALU datapath.
- Waits for ALU completion, with a timeout, and holds the result for display until the next operation.
- Front-end controller of the ALU design; drives the ALU inputs and the result display/LED logic.

Parameters:
- WIDTH, 4, operand width (bits of sw latched into op_a/op_b); must be >= OPW
- OPW, 3, opcode width; taken from sw[OPW-1:0]
- RW, 8, ALU result width
- TIMEOUT, 15, max cycles spent in WAIT without alu_done before error (>= 1)
- TW, 4, timeout counter width; must satisfy 2^TW > TIMEOUT

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- next_p  in  1  debounced "next/confirm" pulse, one cycle per press
- clr_p  in  1  debounced "clear" pulse, one cycle per press
- sw  in  WIDTH  data switches
- alu_result  in  RW  ALU result, valid when alu_done=1
- alu_done  in  1  ALU completion strobe
- op_a  out  WIDTH  latched operand A
- op_b  out  WIDTH  latched operand B
- opcode  out  OPW  latched opcode
- alu_start  out  1  one-cycle start strobe to ALU
- result  out  RW  captured ALU result
- result_valid  out  1  result holds a fresh value
- err  out  1  ALU timeout flag
- step  out  3  current state code, for LEDs

Behaviour:
- Reset (async, rst=1): state=S_A; op_a, op_b, opcode, result, timer = 0; result_valid=0; err=0; alu_start=0.
- State codes: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_WAIT=4, S_SHOW=5, S_ERR=6. Code 7 goes to S_A on the next edge. step = state code.
- S_A: on next_p, op_a<=sw, go to S_B.
- S_B: on next_p, op_b<=sw, go to S_OP.
- S_OP: on next_p, opcode<=sw[OPW-1:0], go to S_EXEC.
- S_EXEC:
  - alu_start=1; decoded from state, so high exactly one cycle, starting the cycle after the third next_p edge.
  - result_valid<=0, timer<=0; go to S_WAIT unconditionally.
- S_WAIT:
  - If alu_done: result<=alu_result, result_valid<=1, go to S_SHOW.
  - Else timer<=timer+1; if the incremented value equals TIMEOUT, err<=1 and go to S_ERR.
  - Net effect: done is accepted in any of the first TIMEOUT cycles of S_WAIT.
  - alu_done in the same cycle that the timer would expire: done wins, no error.
- S_SHOW: result and result_valid held; on next_p go to S_A. Operands are kept, so the user can overwrite them.
- S_ERR: err held at 1; on next_p go to S_A with err<=0.
- alu_done outside S_WAIT is ignored; the ALU must respond at least 1 cycle after alu_start.
- next_p in S_EXEC or S_WAIT is ignored.
- clr_p in any state, highest priority:
  - Next edge goes to S_A; op_a, op_b, opcode, result = 0; result_valid=0; err=0; timer=0.
  - clr_p together with next_p: clr wins and nothing is latched.
  - clr_p during S_EXEC: alu_start still asserts in that cycle; any later alu_done is ignored.
- Async rst mid-operation returns everything to reset values immediately, regardless of state.

Optional Feature:
- Macro: SEQ_EDGE_DETECT_EN.
- Defined: next_p and clr_p are treated as levels (e.g. from an FSM-style debouncer). An internal registered rising-edge detector (reset to 0) derives one-cycle pulses, adding 1 cycle of latency to every button action. Holding a button high advances exactly one step.
- Undefined: inputs are used directly as pulses. A held level advances one state per cycle.

Test Plan:
- Reset, then sw=4'h3+next_p, sw=4'h5+next_p, sw=4'h2+next_p -> op_a=3, op_b=5, opcode=2; alu_start high exactly 1 cycle, the cycle after the third next_p; step: 0,1,2,3,4.
- In S_WAIT, alu_done=1 with alu_result=8'h08 three cycles after start -> result=8'h08, result_valid=1, step=5; then next_p -> step=0, result still 8'h08.
- alu_done never asserted -> err=1 and step=6 exactly TIMEOUT (15) cycles after entering S_WAIT; next_p -> err=0, step=0.
- alu_done on the 15th S_WAIT cycle -> result captured, err stays 0.
- In S_OP, assert next_p and clr_p together -> step=0, op_a=op_b=opcode=0, opcode not latched.
- rst pulse asserted mid-clock during S_WAIT -> all outputs zero immediately, before the next clk edge. With SEQ_EDGE_DETECT_EN, a 10-cycle high next_p level -> a single step advance.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// ----------------------------------------------------------------------------
// alu_operand_sequencer
//
// Front-end controller for the ALU. It walks the user through entering
// operand A, operand B and the opcode from the data switches. It then fires a
// one-cycle start to the ALU and waits for completion, with a timeout. The
// result is held for display until the next operation begins.
//
// Optional build macro: SEQ_EDGE_DETECT_EN
//   defined   : next_p/clr_p are levels. A registered rising-edge detector
//               turns them into pulses, which adds one cycle of latency.
//   undefined : next_p/clr_p are used directly as one-cycle pulses.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   next_p, clr_p     debounced confirm / clear buttons
//   sw                data switches (operands, low OPW bits = opcode)
//   alu_result/done   ALU result and completion strobe
//   op_a, op_b        latched operands
//   opcode            latched opcode
//   alu_start         one-cycle start strobe to the ALU
//   result            captured ALU result
//   result_valid      result holds a fresh value
//   err               ALU timeout flag
//   step              current state code, for the LEDs
// ----------------------------------------------------------------------------
module alu_operand_sequencer #(
    parameter int WIDTH   = 4,
    parameter int OPW     = 3,
    parameter int RW      = 8,
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             next_p,
    input  logic             clr_p,
    input  logic [WIDTH-1:0] sw,
    input  logic [RW-1:0]    alu_result,
    input  logic             alu_done,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [OPW-1:0]   opcode,
    output logic             alu_start,
    output logic [RW-1:0]    result,
    output logic             result_valid,
    output logic             err,
    output logic [2:0]       step
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_WAIT = 3'd4,
        S_SHOW = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [OPW-1:0]   opcode_q, opcode_d;
    logic [RW-1:0]    result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             err_q, err_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [TW-1:0]    timer_inc;
    logic             next_ev, clr_ev;

`ifdef SEQ_EDGE_DETECT_EN
    // Level inputs: the previous level is remembered, and the pulse itself is
    // registered, so every button action lands one cycle later.
    logic next_prev_q, clr_prev_q, next_pls_q, clr_pls_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_prev_q <= 1'b0;
            clr_prev_q  <= 1'b0;
            next_pls_q  <= 1'b0;
            clr_pls_q   <= 1'b0;
        end else begin
            next_prev_q <= next_p;
            clr_prev_q  <= clr_p;
            next_pls_q  <= next_p & ~next_prev_q;
            clr_pls_q   <= clr_p & ~clr_prev_q;
        end
    end

    assign next_ev = next_pls_q;
    assign clr_ev  = clr_pls_q;
`else
    assign next_ev = next_p;
    assign clr_ev  = clr_p;
`endif

    assign timer_inc = timer_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        opcode_d       = opcode_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        err_d          = err_q;
        timer_d        = timer_q;

        case (state_q)
            S_A: if (next_ev) begin
                op_a_d  = sw;
                state_d = S_B;
            end
            S_B: if (next_ev) begin
                op_b_d  = sw;
                state_d = S_OP;
            end
            S_OP: if (next_ev) begin
                opcode_d = sw[OPW-1:0];
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                result_valid_d = 1'b0;
                timer_d        = '0;
                state_d        = S_WAIT;
            end
            S_WAIT: begin
                // Completion beats a timeout that would expire this same cycle.
                if (alu_done) begin
                    result_d       = alu_result;
                    result_valid_d = 1'b1;
                    state_d        = S_SHOW;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == TW'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_SHOW: if (next_ev) state_d = S_A;
            S_ERR: if (next_ev) begin
                err_d   = 1'b0;
                state_d = S_A;
            end
            default: state_d = S_A;   // unused code 7 recovers
        endcase

        // Clear overrides everything, including a simultaneous confirm.
        if (clr_ev) begin
            state_d        = S_A;
            op_a_d         = '0;
            op_b_d         = '0;
            opcode_d       = '0;
            result_d       = '0;
            result_valid_d = 1'b0;
            err_d          = 1'b0;
            timer_d        = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_A;
            op_a_q         <= '0;
            op_b_q         <= '0;
            opcode_q       <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
            timer_q        <= '0;
        end else begin
            state_q        <= state_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            opcode_q       <= opcode_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            err_q          <= err_d;
            timer_q        <= timer_d;
        end
    end

    // Decoded from state, so it is high for exactly the one S_EXEC cycle.
    assign alu_start    = (state_q == S_EXEC);
    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign opcode       = opcode_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign err          = err_q;
    assign step         = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;
    localparam int WIDTH = 4, OPW = 3, RW = 8, TO = 15, TW = 4;

    logic             clk = 1'b0;
    logic             rst, next_p, clr_p, alu_done;
    logic [WIDTH-1:0] sw;
    logic [RW-1:0]    alu_result;
    logic [WIDTH-1:0] op_a, op_b;
    logic [OPW-1:0]   opcode;
    logic             alu_start, result_valid, err;
    logic [RW-1:0]    result;
    logic [2:0]       step;

    int ncmp = 0;
    int nerr = 0;

    // Expected-value model: what the user has entered and what was captured.
    int m_a, m_b, m_op, m_res, m_vld;

    alu_operand_sequencer #(.WIDTH(WIDTH), .OPW(OPW), .RW(RW), .TIMEOUT(TO), .TW(TW)) dut (
        .clk(clk), .rst(rst), .next_p(next_p), .clr_p(clr_p), .sw(sw),
        .alu_result(alu_result), .alu_done(alu_done),
        .op_a(op_a), .op_b(op_b), .opcode(opcode), .alu_start(alu_start),
        .result(result), .result_valid(result_valid), .err(err), .step(step)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Extra settle cycle for the registered edge detector in level mode.
    task automatic lat();
`ifdef SEQ_EDGE_DETECT_EN
        tick();
`endif
    endtask

    // One press of next; returns once the sequencer has acted on it.
    // alu_done noise is driven to show it is ignored outside S_WAIT.
    task automatic press(input logic [WIDTH-1:0] v);
        sw = v; next_p = 1'b1;
        alu_done = 1'($urandom_range(0, 1)); alu_result = 8'($urandom);
        tick();
        next_p = 1'b0; alu_done = 1'b0;
        lat();
    endtask

    task automatic clear();
        clr_p = 1'b1; tick(); clr_p = 1'b0; lat();
        m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_vld = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_step"}, 32'(step), 0);
        chk({tag, "_opa"}, 32'(op_a), 0);
        chk({tag, "_opb"}, 32'(op_b), 0);
        chk({tag, "_opc"}, 32'(opcode), 0);
        chk({tag, "_res"}, 32'(result), 0);
        chk({tag, "_vld"}, 32'(result_valid), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_start"}, 32'(alu_start), 0);
    endtask

    // Enter three values and reach S_WAIT, checking the entry path.
    task automatic enter(input int a, input int b, input int op);
        press(4'(a)); m_a = a;
        chk("stepB", 32'(step), 1); chk("opa", 32'(op_a), 32'(m_a));
        press(4'(b)); m_b = b;
        chk("stepOP", 32'(step), 2); chk("opb", 32'(op_b), 32'(m_b));
        press(4'(op)); m_op = op % (1 << OPW);
        chk("stepEX", 32'(step), 3); chk("opc", 32'(opcode), 32'(m_op));
        chk("start_hi", 32'(alu_start), 1);
        tick();
        m_vld = 0;
        chk("stepW", 32'(step), 4); chk("start_lo", 32'(alu_start), 0);
        chk("vld_clr", 32'(result_valid), 0);
    endtask

    // Full operation: ALU answers on WAIT cycle d (1-based); d > TO means never.
    task automatic run_op(input int a, input int b, input int op, input int d, input int res);
        bit fin = 0;
        enter(a, b, op);
        for (int c = 1; c <= TO && !fin; c++) begin
            alu_done = (c == d);
            alu_result = (c == d) ? 8'(res) : 8'($urandom);
            tick();
            alu_done = 1'b0;
            if (c == d) begin
                m_res = res; m_vld = 1; fin = 1;
                chk("show_step", 32'(step), 5);
                chk("show_res", 32'(result), 32'(m_res));
                chk("show_vld", 32'(result_valid), 1);
                chk("show_err", 32'(err), 0);
            end else if (c == TO) begin
                fin = 1;
                chk("to_step", 32'(step), 6);
                chk("to_err", 32'(err), 1);
                chk("to_vld", 32'(result_valid), 0);
                chk("to_res", 32'(result), 32'(m_res));
            end else begin
                chk("wait_step", 32'(step), 4);
            end
        end
        // Late completions must not disturb the held state.
        alu_done = 1'b1; alu_result = 8'($urandom); tick(); alu_done = 1'b0;
        chk("hold_res", 32'(result), 32'(m_res));
        chk("hold_step", 32'(step), (d <= TO) ? 5 : 6);
        press(4'($urandom));
        chk("back_step", 32'(step), 0);
        chk("back_err", 32'(err), 0);
        chk("back_res", 32'(result), 32'(m_res));
        chk("back_vld", 32'(result_valid), 32'(m_vld));
        chk("back_opa", 32'(op_a), 32'(m_a));
    endtask

    initial begin
        rst = 1'b1; next_p = 1'b0; clr_p = 1'b0; alu_done = 1'b0;
        sw = '0; alu_result = '0;
        m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_vld = 0;
        tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Directed: 3,5,2 with completion on WAIT cycle 3.
        run_op(3, 5, 2, 3, 8'h08);
        // Timeout, then completion exactly on the last allowed cycle.
        run_op(4'h9, 4'h1, 4'h7, 99, 8'hAA);
        run_op(4'hF, 4'hE, 4'hD, TO, 8'h5C);
        run_op(4'h1, 4'h2, 4'h3, 1, 8'hFF);

        // Random operations around the timeout boundary.
        for (int i = 0; i < 10; i++)
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), int'($urandom_range(1, TO + 3)),
                   int'($urandom_range(0, 255)));

        // Clear together with next in S_OP: clear wins, nothing latched.
        press(4'h6); press(4'hA);
        chk("pre_clr_step", 32'(step), 2);
        sw = 4'h7; next_p = 1'b1; clr_p = 1'b1;
        tick();
        next_p = 1'b0; clr_p = 1'b0;
        lat();
        m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_vld = 0;
        chk_all_zero("clr_next");

`ifndef SEQ_EDGE_DETECT_EN
        // Clear during S_EXEC: start still fires, later completion ignored.
        press(4'h2); press(4'h3); press(4'h4);
        chk("cx_start", 32'(alu_start), 1);
        clr_p = 1'b1; tick(); clr_p = 1'b0;
        m_a = 0; m_b = 0; m_op = 0;
        chk_all_zero("clr_exec");
        alu_done = 1'b1; alu_result = 8'h77; tick(); alu_done = 1'b0;
        chk_all_zero("clr_exec_done");

        // Held level without edge detection advances once per cycle.
        sw = 4'h5; next_p = 1'b1; tick(); tick(); next_p = 1'b0;
        chk("lvl_step", 32'(step), 2);
        chk("lvl_opb", 32'(op_b), 5);
        clear();
`else
        // Held level with edge detection advances exactly one step.
        sw = 4'h5; next_p = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        next_p = 1'b0; tick();
        chk("lvl_step", 32'(step), 1);
        chk("lvl_opa", 32'(op_a), 5);
        clear();
`endif

        // Asynchronous reset mid-clock while waiting on the ALU.
        enter(4'hC, 4'h3, 4'h5);
        tick();
        #2 rst = 1'b1;
        #1;
        m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_vld = 0;
        chk_all_zero("async_rst");
        tick();
        rst = 1'b0;
        tick();
        run_op(4'h8, 4'h4, 4'h1, 2, 8'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
